// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Replicated across the result width to form the diff reset value.
  localparam logic RESULT_RST = 1'b0;

endpackage

// File: rtl/serial_sub_if.sv
// Start/done handshake bundle between a requester and the serial subtractor.
interface serial_sub_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );

endinterface

// File: rtl/serial_sub_fs.sv
// One-bit combinational full subtractor, the dual of the full-adder cell.
module fs (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: one fs slice reused LSB-first over WIDTH cycles.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic        clk,
  input logic        rst_n,
  serial_sub_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_next;
  logic [WIDTH-1:0] sa, sb, sr, sr_next;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             br, br_next, d;
  logic [CW-1:0]    cnt;
  logic             load, step, last;

  fs u_fs (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (br),
    .d    (d),
    .bout (br_next)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  // The newest difference bit enters at the MSB so the LSB-first stream lands aligned.
  generate
    if (WIDTH == 1) begin : g_sr1
      assign sr_next = d;
    end else begin : g_srn
      assign sr_next = {d, sr[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = SHIFT;
          load       = 1'b1;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_next = SHIFT;
          load       = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // diff/bout are separate from sr so the previous result stays visible during a new operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      sr     <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff_q <= {WIDTH{RESULT_RST}};
      bout_q <= RESULT_RST;
    end else if (load) begin
      sa  <= bus.a;
      sb  <= bus.b;
      br  <= bus.bin;
      cnt <= '0;
    end else if (step) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      sr  <= sr_next;
      br  <= br_next;
      cnt <= cnt + 1'b1;
      if (last) begin
        diff_q <= sr_next;
        bout_q <= br_next;
      end
    end
  end

  assign bus.busy = (state == SHIFT);
  assign bus.done = (state == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub at WIDTH 8, 4 and 1.
module tb_serial_sub;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;

  typedef struct {
    logic [7:0] diff;
    logic       bout;
    int         cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];
  exp_t q1[$];

  serial_sub_if #(.WIDTH(8)) if8 ();
  serial_sub_if #(.WIDTH(4)) if4 ();
  serial_sub_if #(.WIDTH(1)) if1 ();

  serial_sub #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_sub #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  serial_sub #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitors: pop one expectation per done pulse; busy must have been high for exactly WIDTH cycles.
  int   run8 = 0, run4 = 0, run1 = 0;
  logic pd8 = 1'b0, pd4 = 1'b0, pd1 = 1'b0;

  always @(negedge clk) begin : mon8
    exp_t e;
    if (if8.done === 1'b1) begin
      checkOutput("u8 busy run", 32'(run8), 32'd8);
      checkOutput("u8 busy at done", 32'(if8.busy), 32'd0);
      checkOutput("u8 done pulse", 32'(pd8), 32'd0);
      if (q8.size() == 0) begin
        total++;
        $display("[TB] FAIL u8 unexpected done: got done=1 expected no pending op");
      end else begin
        e = q8.pop_front();
        checkOutput("u8 diff", 32'(if8.diff), 32'(e.diff));
        checkOutput("u8 bout", 32'(if8.bout), 32'(e.bout));
        checkOutput("u8 done cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    run8 = (if8.busy === 1'b1) ? run8 + 1 : 0;
    pd8  = (if8.done === 1'b1);
  end

  always @(negedge clk) begin : mon4
    exp_t e;
    if (if4.done === 1'b1) begin
      checkOutput("u4 busy run", 32'(run4), 32'd4);
      if (q4.size() == 0) begin
        total++;
        $display("[TB] FAIL u4 unexpected done: got done=1 expected no pending op");
      end else begin
        e = q4.pop_front();
        checkOutput("u4 diff", 32'(if4.diff), 32'(e.diff[3:0]));
        checkOutput("u4 bout", 32'(if4.bout), 32'(e.bout));
        checkOutput("u4 done cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    run4 = (if4.busy === 1'b1) ? run4 + 1 : 0;
    pd4  = (if4.done === 1'b1);
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (if1.done === 1'b1) begin
      checkOutput("u1 busy run", 32'(run1), 32'd1);
      if (q1.size() == 0) begin
        total++;
        $display("[TB] FAIL u1 unexpected done: got done=1 expected no pending op");
      end else begin
        e = q1.pop_front();
        checkOutput("u1 diff", 32'(if1.diff), 32'(e.diff[0]));
        checkOutput("u1 bout", 32'(if1.bout), 32'(e.bout));
        checkOutput("u1 done cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    run1 = (if1.busy === 1'b1) ? run1 + 1 : 0;
    pd1  = (if1.done === 1'b1);
  end

  // Called at a negedge; issues one op on the selected instance and waits (bounded) for its done.
  task automatic applyStimulus(input int which, input logic [7:0] a, input logic [7:0] b,
                               input logic bin, input logic [7:0] ed, input logic eb);
    exp_t e;
    logic seen;
    e.diff = ed;
    e.bout = eb;
    e.cyc  = cyc + 1 + which;
    case (which)
      8: begin if8.a = a; if8.b = b; if8.bin = bin; if8.start = 1'b1; q8.push_back(e); end
      4: begin if4.a = a[3:0]; if4.b = b[3:0]; if4.bin = bin; if4.start = 1'b1; q4.push_back(e); end
      default: begin if1.a = a[0]; if1.b = b[0]; if1.bin = bin; if1.start = 1'b1; q1.push_back(e); end
    endcase
    @(negedge clk);
    if8.start = 1'b0;
    if4.start = 1'b0;
    if1.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < which + 3 && !seen; i++) begin
      @(negedge clk);
      case (which)
        8:       seen = (if8.done === 1'b1);
        4:       seen = (if4.done === 1'b1);
        default: seen = (if1.done === 1'b1);
      endcase
    end
    if (!seen) begin
      total++;
      $display("[TB] FAIL done timeout w%0d: got no done expected done within %0d cycles", which, which + 3);
    end
  endtask

  initial begin : stim
    logic [4:0] r5;
    exp_t       e;
    int         n;
    if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.bin = 1'b0;
    if4.start = 1'b0; if4.a = '0; if4.b = '0; if4.bin = 1'b0;
    if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.bin = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 32'(if8.busy), 32'd0);
    checkOutput("reset done", 32'(if8.done), 32'd0);
    checkOutput("reset diff", 32'(if8.diff), 32'd0);
    checkOutput("reset bout", 32'(if8.bout), 32'd0);
    checkOutput("reset u4 diff", 32'(if4.diff), 32'd0);
    checkOutput("reset u1 bout", 32'(if1.bout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] basic subtraction");
    applyStimulus(8, 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
    @(negedge clk);
    applyStimulus(8, 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);
    applyStimulus(8, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    @(negedge clk);

    $display("[TB] start held high, back-to-back");
    n = cyc;
    if8.a = 8'h33; if8.b = 8'h11; if8.bin = 1'b0; if8.start = 1'b1;
    e.diff = 8'h22; e.bout = 1'b0; e.cyc = n + 9;  q8.push_back(e);
    e.diff = 8'hEF; e.bout = 1'b1; e.cyc = n + 18; q8.push_back(e);
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (k == 1) begin if8.a = 8'h10; if8.b = 8'h20; if8.bin = 1'b1; end
      if (k == 4) checkOutput("hold diff op1", 32'(if8.diff), 32'hFF);
      if (k == 4) checkOutput("hold bout op1", 32'(if8.bout), 32'd1);
      if (k == 10) if8.start = 1'b0;
      if (k == 13) checkOutput("hold diff op2", 32'(if8.diff), 32'h22);
    end

    $display("[TB] reset mid-operation");
    if8.a = 8'h77; if8.b = 8'h11; if8.bin = 1'b0; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", 32'(if8.busy), 32'd0);
    checkOutput("abort done", 32'(if8.done), 32'd0);
    checkOutput("abort diff", 32'(if8.diff), 32'd0);
    checkOutput("abort bout", 32'(if8.bout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(8, 8'd5, 8'd3, 1'b0, 8'd2, 1'b0);

    $display("[TB] exhaustive WIDTH=4");
    @(negedge clk);
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          r5 = 5'(a) - 5'(b) - 5'(c);
          applyStimulus(4, 8'(a), 8'(b), c[0], {4'd0, r5[3:0]}, r5[4]);
        end
      end
    end

    $display("[TB] WIDTH=1");
    @(negedge clk);
    applyStimulus(1, 8'd0, 8'd1, 1'b1, 8'd0, 1'b1);
    repeat (3) @(negedge clk);

    checkOutput("u8 pending", 32'(q8.size()), 32'd0);
    checkOutput("u4 pending", 32'(q4.size()), 32'd0);
    checkOutput("u1 pending", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
